// File: rtl/count_bcd_decoder.sv
// Serial binary-to-BCD converter (shift-add-3), one input bit per clock.
// Sits between the free-running count and the digit renderer; start/busy/done handshake.
//
// state   | meaning
// S_IDLE  | waiting for start; bcd holds last result
// S_SHIFT | one add-3/shift step per clock, WIDTH steps total
// S_DONE  | publish scratch to bcd, pulse done
module count_bcd_decoder #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [4*DIGITS-1:0] scratch_q, scratch_d;
  logic [4*DIGITS-1:0] adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Digits >= 5 are corrected before the shift so they carry correctly into the next digit.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = '0;
        end
      end
      S_SHIFT: begin
        {scratch_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q + CW'(1);
      end
      S_DONE: begin
        bcd_d  = scratch_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    bcd  = bcd_q;
  end

endmodule

// File: tb/tb_count_bcd_decoder.sv
// Bench for count_bcd_decoder: transaction-level model (accept time + decimal digits
// by division) checked every cycle, plus directed cases with literal results.
module tb_count_bcd_decoder;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int LAT    = WIDTH + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;

  int tests = 0;
  int fails = 0;

  count_bcd_decoder #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .bcd  (bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Model: age = cycles since accepted start (-1 when idle).
  int                  m_age   = -1;
  int                  m_val   = 0;
  logic [4*DIGITS-1:0] m_bcd   = '0;
  logic                m_done  = 1'b0;
  bit                  m_valid = 1'b0;
  int                  cyc_n   = 0;
  int                  done_cnt = 0;
  int                  last_done_cyc = 0;
  int                  prev_done_cyc = 0;

  always @(posedge clk) begin
    cyc_n++;
    if (rst) begin
      m_age   = -1;
      m_bcd   = '0;
      m_done  = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_done = 1'b0;
      if (m_age < 0) begin
        if (start) begin
          m_age = 0;
          m_val = int'(bin);
        end
      end else begin
        m_age++;
        if (m_age == LAT) begin
          m_age  = -1;
          m_bcd  = to_bcd(m_val);
          m_done = 1'b1;
        end
      end
    end
    #1;
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_age >= 0));
      chk("done", 32'(done), 32'(m_done));
      chk("bcd",  32'(bcd),  32'(m_bcd));
      if (done) begin
        done_cnt++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc_n;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [WIDTH-1:0] v);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic convert(input string nm, input int v, input logic [4*DIGITS-1:0] exp);
    int d0;
    int s;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    bin   = WIDTH'(v);
    s = cyc_n;
    @(negedge clk);
    start = 1'b0;
    bin   = WIDTH'($urandom);
    cycles(LAT + 2);
    chk({nm, "_bcd"}, 32'(bcd), 32'(exp));
    chk({nm, "_ndone"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, "_lat"}, 32'(last_done_cyc - s), 32'(LAT + 1));
  endtask

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;

    // T1
    cycles(2);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_bcd",  32'(bcd),  32'h00000);

    // T2/T3
    convert("t2_zero", 0,     20'h00000);
    convert("t3_1234", 1234,  20'h01234);
    convert("t3_max",  65535, 20'h65535);
    convert("t3_9",    9,     20'h00009);
    convert("t3_10",   10,    20'h00010);
    convert("t3_99",   99,    20'h00099);
    convert("t3_4095", 4095,  20'h04095);

    // T4: start while busy ignored
    d0 = done_cnt;
    pulse_start(16'd500);
    cycles(2);
    start = 1'b1;
    bin   = 16'd777;
    @(negedge clk);
    start = 1'b0;
    cycles(LAT + 2);
    chk("t4_bcd",   32'(bcd), 32'h00500);
    chk("t4_ndone", 32'(done_cnt - d0), 32'd1);

    // T5: reset mid-conversion
    d0 = done_cnt;
    pulse_start(16'd4321);
    cycles(7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_bcd",  32'(bcd),  32'h00000);
    cycles(LAT + 2);
    chk("t5_nodone", 32'(done_cnt - d0), 32'd0);
    convert("t5_42", 42, 20'h00042);

    // T6: start held high
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd123;
    cycles(60);
    start = 1'b0;
    chk("t6_ndone",  32'(done_cnt - d0), 32'd3);
    chk("t6_period", 32'(last_done_cyc - prev_done_cyc), 32'(LAT + 1));
    chk("t6_bcd",    32'(bcd), 32'h00123);
    cycles(LAT + 2);

    // Random traffic: sparse starts, noisy bin, occasional reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      bin   = WIDTH'($urandom);
      rst   = ($urandom_range(0, 299) == 0);
    end
    rst   = 1'b0;
    start = 1'b0;
    cycles(LAT + 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
